// File: rtl/qdma_master_2908_pkg.sv
// qdma_master_2908_pkg: state encodings, QBUS timing defaults and shared types for the DMA master
package qdma_master_2908_pkg;
  localparam int D_SETTLE = 1, D_ADDR_SETUP = 3, D_ADDR_HOLD = 2, D_DATA_SETUP = 2, D_TIMEOUT = 200;
  localparam int DATA_HOLD = 2;
  localparam logic [3:0] QDM_IDLE = 4'd0, QDM_REQ = 4'd1, QDM_WAITBUS = 4'd2, QDM_ALOAD = 4'd3,
    QDM_ALST = 4'd4, QDM_ASETUP = 4'd5, QDM_AHOLD = 4'd6, QDM_DLOAD = 4'd7, QDM_DLST = 4'd8,
    QDM_DSETUP = 4'd9, QDM_DWAIT = 4'd10, QDM_DHOLD = 4'd11, QDM_RWAIT = 4'd12, QDM_RCAP = 4'd13,
    QDM_END = 4'd14;
  typedef struct packed {
    logic        write;
    logic [21:0] addr;
    logic [15:0] wdata;
  } req_t;
  typedef struct packed {
    logic        tdmr, tsack, tsync, tdin, tdout;
    logic        adal, daltx, dalst, dalbe, twtbt;
    logic        done, nxm;
    logic [21:0] dal;
    logic [15:0] rdata;
  } out_t;
endpackage

// File: rtl/qdma_master_2908_if.sv
// qdma_master_2908_if: client request/response, QBUS driver/receiver and qctl_2908 datapath controls
interface qdma_master_2908_if;
  logic        req, req_write;
  logic [21:0] req_addr;
  logic [15:0] req_wdata;
  logic        done, nxm;
  logic [15:0] rdata;
  logic        RDMGI, TDMGO, TDMR, TSACK, TSYNC, TDIN, TDOUT;
  logic        RSYNC, RRPLY, RDMR;
  logic [15:0] RDAL;
  logic        dma_assert_dal, dma_daltx, dma_dalst, dma_dalbe, dma_twtbt;
  logic [21:0] dma_dal;
  modport master (
    input  req, req_write, req_addr, req_wdata, RDMGI, RSYNC, RRPLY, RDMR, RDAL,
    output done, nxm, rdata, TDMGO, TDMR, TSACK, TSYNC, TDIN, TDOUT,
           dma_assert_dal, dma_daltx, dma_dalst, dma_dalbe, dma_twtbt, dma_dal
  );
  modport slave (
    output req, req_write, req_addr, req_wdata, RDMGI, RSYNC, RRPLY, RDMR, RDAL,
    input  done, nxm, rdata, TDMGO, TDMR, TSACK, TSYNC, TDIN, TDOUT,
           dma_assert_dal, dma_daltx, dma_dalst, dma_dalbe, dma_twtbt, dma_dal
  );
endinterface

// File: rtl/qdma_master_2908_sync.sv
// qdma_master_2908_sync: N-flop synchronizer for asynchronous QBUS receiver lines
module qdma_master_2908_sync #(
  parameter int W = 1,
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [N-1:0][W-1:0] sh_q;
  always_ff @(posedge clk)
    if (reset) sh_q <= '0;
    else sh_q <= {sh_q[N-2:0], d_i};
  assign q_o = sh_q[N-1];
endmodule

// File: rtl/qdma_master_2908.sv
// qdma_master_2908: QBUS DMA bus master sequencing one DATI/DATO per tenure through qctl_2908
module qdma_master_2908
  import qdma_master_2908_pkg::*;
#(
  parameter int SETTLE     = D_SETTLE,
  parameter int ADDR_SETUP = D_ADDR_SETUP,
  parameter int ADDR_HOLD  = D_ADDR_HOLD,
  parameter int DATA_SETUP = D_DATA_SETUP,
  parameter int TIMEOUT    = D_TIMEOUT
) (
  input logic                clk,
  input logic                reset,
  qdma_master_2908_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [3:0] s_q, s_d;
  logic [CW-1:0] c_q, c_d;
  req_t r_q, r_d;
  out_t o_q, o_d;
  logic tdmgo_q, sdmg, ssync, srply, last, fin, abort;
  qdma_master_2908_sync #(.W(3), .N(2)) u_sync (
    .clk(clk), .reset(reset),
    .d_i({bus.RDMGI, bus.RSYNC, bus.RRPLY}),
    .q_o({sdmg, ssync, srply})
  );
  // one down-counter times every phase: loading N keeps the state for N clocks
  assign last = c_q <= CW'(1);
  always_comb begin
    s_d = s_q;
    r_d = r_q;
    o_d = o_q;
    o_d.dalst = 1'b0;
    o_d.done = 1'b0;
    o_d.nxm = 1'b0;
    c_d = (c_q != '0) ? c_q - CW'(1) : c_q;
    fin = 1'b0;
    abort = 1'b0;
    case (s_q)
      QDM_IDLE: if (bus.req) begin
        r_d = {bus.req_write, bus.req_addr, bus.req_wdata};
        o_d.tdmr = 1'b1;
        s_d = QDM_REQ;
      end
      QDM_REQ: if (sdmg) begin
        o_d.tdmr = 1'b0;
        o_d.tsack = 1'b1;
        s_d = QDM_WAITBUS;
      end
      QDM_WAITBUS: if (!ssync && !srply) begin
        o_d.adal = 1'b1;
        o_d.daltx = 1'b1;
        o_d.dal = r_q.addr;
        o_d.twtbt = r_q.write;
        c_d = CW'(SETTLE);
        s_d = QDM_ALOAD;
      end
      QDM_ALOAD: if (last) begin
        o_d.dalst = 1'b1;
        s_d = QDM_ALST;
      end
      QDM_ALST: begin
        o_d.dalbe = 1'b1;
        c_d = CW'(ADDR_SETUP);
        s_d = QDM_ASETUP;
      end
      QDM_ASETUP: if (last) begin
        o_d.tsync = 1'b1;
        c_d = CW'(ADDR_HOLD);
        s_d = QDM_AHOLD;
      end
      QDM_AHOLD: if (last) begin
        o_d.dalbe = 1'b0;
        o_d.twtbt = 1'b0;
        o_d.dal = r_q.write ? {6'b0, r_q.wdata} : o_q.dal;
        o_d.daltx = r_q.write;
        o_d.tdin = !r_q.write;
        c_d = r_q.write ? CW'(SETTLE) : CW'(TIMEOUT);
        s_d = r_q.write ? QDM_DLOAD : QDM_RWAIT;
      end
      QDM_DLOAD: if (last) begin
        o_d.dalst = 1'b1;
        s_d = QDM_DLST;
      end
      QDM_DLST: begin
        o_d.dalbe = 1'b1;
        c_d = CW'(DATA_SETUP);
        s_d = QDM_DSETUP;
      end
      QDM_DSETUP: if (last) begin
        o_d.tdout = 1'b1;
        c_d = CW'(TIMEOUT);
        s_d = QDM_DWAIT;
      end
      QDM_DWAIT: if (srply) begin
        o_d.tdout = 1'b0;
        c_d = CW'(DATA_HOLD);
        s_d = QDM_DHOLD;
      end else if (last) begin
        fin = 1'b1;
        abort = 1'b1;
      end
      QDM_DHOLD: if (last) begin
        o_d.dalbe = 1'b0;
        o_d.daltx = 1'b0;
        o_d.adal = 1'b0;
        s_d = QDM_END;
      end
      QDM_RWAIT: if (srply) s_d = QDM_RCAP;
        else if (last) begin
          fin = 1'b1;
          abort = 1'b1;
        end
      QDM_RCAP: begin
        o_d.rdata = bus.RDAL;
        o_d.tdin = 1'b0;
        s_d = QDM_END;
      end
      QDM_END: fin = !srply;
      default: s_d = QDM_IDLE;
    endcase
    // a timeout skips the RRPLY-negate wait and releases everything at once
    if (fin) begin
      o_d = '0;
      o_d.rdata = o_q.rdata;
      o_d.done = 1'b1;
      o_d.nxm = abort;
      s_d = QDM_IDLE;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      s_q <= QDM_IDLE;
      c_q <= '0;
      r_q <= '0;
      o_q <= '0;
      tdmgo_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
      r_q <= r_d;
      o_q <= o_d;
      tdmgo_q <= sdmg & (s_q != QDM_REQ);
    end
  assign bus.TDMGO = tdmgo_q;
  assign bus.TDMR = o_q.tdmr;
  assign bus.TSACK = o_q.tsack;
  assign bus.TSYNC = o_q.tsync;
  assign bus.TDIN = o_q.tdin;
  assign bus.TDOUT = o_q.tdout;
  assign bus.dma_assert_dal = o_q.adal;
  assign bus.dma_daltx = o_q.daltx;
  assign bus.dma_dalst = o_q.dalst;
  assign bus.dma_dalbe = o_q.dalbe;
  assign bus.dma_twtbt = o_q.twtbt;
  assign bus.dma_dal = o_q.dal;
  assign bus.done = o_q.done;
  assign bus.nxm = o_q.nxm;
  assign bus.rdata = o_q.rdata;
endmodule

// File: tb/tb_qdma_master_2908.sv
// tb_qdma_master_2908: directed QBUS master scenarios with a done/nxm/rdata scoreboard
module tb_qdma_master_2908;
  typedef struct packed {
    logic        nxm;
    logic [15:0] rdata;
  } exp_t;
  localparam int I_TDMR = 0, I_TSACK = 1, I_TSYNC = 2, I_TDIN = 3, I_TDOUT = 4, I_ADAL = 5,
    I_DALTX = 6, I_DALST = 7, I_DALBE = 8, I_TWTBT = 9, I_DONE = 10, I_NXM = 11, I_TDMGO = 12;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0, total = 0, passed = 0, done_cnt = 0, viol = 0;
  exp_t exp_q[$];
  logic [12:0] obs;
  qdma_master_2908_if bus();
  qdma_master_2908 dut (.clk(clk), .reset(reset), .bus(bus));
  assign obs = {bus.TDMGO, bus.nxm, bus.done, bus.dma_twtbt, bus.dma_dalbe, bus.dma_dalst,
                bus.dma_daltx, bus.dma_assert_dal, bus.TDOUT, bus.TDIN, bus.TSYNC, bus.TSACK, bus.TDMR};
  always #25 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic wait_for(input int idx, input logic lvl, input int lim, input string nm, output int t);
    int n = 0;
    while (obs[idx] !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (obs[idx] === lvl) passed++;
    else $display("FAIL %s: signal still %b after %0d clk, wanted %b", nm, obs[idx], lim, lvl);
    t = cyc;
  endtask
  task automatic issue(input logic w, input logic [21:0] a, input logic [15:0] d);
    bus.req = 1'b1;
    bus.req_write = w;
    bus.req_addr = a;
    bus.req_wdata = d;
    @(negedge clk);
    bus.req = 1'b0;
  endtask
  task automatic grant();
    int t;
    wait_for(I_TDMR, 1'b1, 5, "tdmr", t);
    bus.RDMGI = 1'b1;
    wait_for(I_TSACK, 1'b1, 8, "tsack", t);
    bus.RDMGI = 1'b0;
  endtask
  task automatic finish_dati(input string nm);
    int t;
    wait_for(I_TDIN, 1'b1, 30, {nm, "_tdin"}, t);
    chk({nm, "_tdin_dalbe"}, {obs[I_DALBE], obs[I_DALTX]}, 0);
    repeat (4) @(negedge clk);
    bus.RRPLY = 1'b1;
    wait_for(I_TDIN, 1'b0, 10, {nm, "_tdin_off"}, t);
    bus.RRPLY = 1'b0;
    wait_for(I_DONE, 1'b1, 10, {nm, "_done"}, t);
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (bus.done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL done_unexpected: done=1 with no transaction outstanding");
        end else begin
          e = exp_q.pop_front();
          chk("sb_nxm", bus.nxm, e.nxm);
          chk("sb_rdata", bus.rdata, e.rdata);
        end
      end
      if ((bus.dma_dalbe & ~bus.dma_daltx) | (bus.TDIN & bus.TDOUT) | (bus.dma_dalst & ~bus.dma_daltx) |
          (bus.TDIN & bus.dma_dalbe) | (bus.TDMR & bus.TDMGO))
        viol++;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t, t0, t1, busy;
    {bus.req, bus.req_write, bus.req_addr, bus.req_wdata} = '0;
    {bus.RDMGI, bus.RSYNC, bus.RRPLY, bus.RDMR, bus.RDAL} = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {obs, bus.dma_dal, bus.rdata}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    // DATO
    exp_q.push_back('{1'b0, 16'h0});
    issue(1'b1, 22'o17772000, 16'o123456);
    wait_for(I_TDMR, 1'b1, 5, "dato_tdmr", t);
    repeat (5) @(negedge clk);
    bus.RDMGI = 1'b1;
    wait_for(I_TSACK, 1'b1, 8, "dato_tsack", t);
    chk("dato_tdmr_off", obs[I_TDMR], 0);
    bus.RDMGI = 1'b0;
    wait_for(I_DALBE, 1'b1, 12, "dato_addr_dalbe", t0);
    chk("dato_addr", bus.dma_dal, 22'o17772000);
    chk("dato_twtbt", obs[I_TWTBT], 1);
    wait_for(I_TSYNC, 1'b1, 10, "dato_tsync", t1);
    chk("addr_setup", t1 - t0, 3);
    wait_for(I_DALBE, 1'b0, 10, "dato_addr_release", t);
    chk("dato_twtbt_off", obs[I_TWTBT], 0);
    wait_for(I_DALBE, 1'b1, 10, "dato_data_dalbe", t0);
    chk("dato_data", bus.dma_dal, {6'b0, 16'o123456});
    wait_for(I_TDOUT, 1'b1, 10, "dato_tdout", t1);
    chk("data_setup", t1 - t0, 2);
    repeat (6) @(negedge clk);
    bus.RRPLY = 1'b1;
    wait_for(I_TDOUT, 1'b0, 10, "dato_tdout_off", t);
    repeat (4) @(negedge clk);
    chk("dato_tsync_held", obs[I_TSYNC:I_TSACK], 2'b11);
    bus.RRPLY = 1'b0;
    wait_for(I_DONE, 1'b1, 10, "dato_done", t);
    chk("dato_release", obs[I_TSYNC:I_TDMR], 0);
    repeat (3) @(negedge clk);
    // DATI
    bus.RDAL = 16'o052525;
    exp_q.push_back('{1'b0, 16'o052525});
    issue(1'b0, 22'o1000, 16'h0);
    grant();
    finish_dati("dati");
    repeat (3) @(negedge clk);
    // NXM timeout
    exp_q.push_back('{1'b1, 16'o052525});
    issue(1'b0, 22'o17000000, 16'h0);
    grant();
    wait_for(I_TDIN, 1'b1, 30, "nxm_tdin", t0);
    wait_for(I_DONE, 1'b1, 260, "nxm_done", t1);
    chk("nxm_timeout", t1 - t0, 200);
    chk("nxm_idle", obs[I_DALBE:I_TDMR], 0);
    repeat (3) @(negedge clk);
    // grant pass-through while idle
    bus.RDMGI = 1'b1;
    wait_for(I_TDMGO, 1'b1, 3, "grant_pass", t);
    bus.RDMGI = 1'b0;
    wait_for(I_TDMGO, 1'b0, 5, "grant_drop", t);
    // bus busy: another master still holds RSYNC when our grant arrives
    bus.RSYNC = 1'b1;
    bus.RDAL = 16'o001234;
    exp_q.push_back('{1'b0, 16'o001234});
    issue(1'b0, 22'o2000, 16'h0);
    grant();
    chk("grant_blocked", viol, 0);
    busy = 0;
    repeat (8) begin
      @(negedge clk);
      busy += int'(obs[I_DALBE] | obs[I_TSYNC] | obs[I_DALTX]);
    end
    chk("busy_hold", busy, 0);
    chk("busy_tsack", obs[I_TSACK], 1);
    bus.RSYNC = 1'b0;
    wait_for(I_DALBE, 1'b1, 12, "busy_dalbe", t);
    finish_dati("busy");
    repeat (3) @(negedge clk);
    // reset while waiting for the DATO reply
    issue(1'b1, 22'o3000, 16'hbeef);
    grant();
    wait_for(I_TDOUT, 1'b1, 30, "rst_tdout", t);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_midcycle", {obs, bus.dma_dal, bus.rdata}, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("done_count", done_cnt, 4);
    chk("invariants", viol, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
